// File: rtl/instr_encoder_loader.sv
// Opcode definitions and a loader that packs instruction fields into 32-bit words
// and streams them into instruction memory, tracking word count and XOR checksum.
package instr_encoder_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_RET   = 6'h11;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

module instr_encoder_loader
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int FUNC_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [5:0]            op,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [FUNC_SIZE-1:0]  func,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W:0] CAPACITY = {{CNT_W{1'b0}}, 1'b1} << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  pend_last_q, pend_last_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      word_count_q, word_count_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  err_q, err_d;

    logic [CNT_W:0]        occupancy;
    logic [CNT_W-1:0]      wc_inc;
    logic                  in_ready_c;
    logic                  accept;
    logic                  write_fills;

    function automatic logic op_is_defined(input logic [5:0] opc);
        logic ok;
        case (opc)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_RET, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // func is zero-extended (or truncated) to the 6-bit field of the word.
    function automatic logic [31:0] encode(
        input logic [5:0]           opc,
        input logic [4:0]           f_rs,
        input logic [4:0]           f_rt,
        input logic [4:0]           f_rd,
        input logic [FUNC_SIZE-1:0] f_func,
        input logic [15:0]          f_imm,
        input logic [25:0]          f_target
    );
        logic [31:0] word;
        logic [5:0]  func6;
        func6 = 6'(f_func);
        case (opc)
            OP_RTYPE, OP_RET: word = {opc, f_rs, f_rt, f_rd, 5'b0, func6};
            OP_J, OP_JAL:     word = {opc, f_target};
            default:          word = {opc, f_rs, f_rt, f_imm};
        endcase
        return word;
    endfunction

    always_comb begin
        occupancy   = {1'b0, word_count_q} + {{CNT_W{1'b0}}, pend_q};
        wc_inc      = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        write_fills = ({1'b0, wc_inc} == CAPACITY);
        // Once the final word is in flight no further bundle may slip in.
        in_ready_c  = (state_q == S_LOAD) && !pend_last_q && (occupancy < CAPACITY);
        accept      = in_valid && in_ready_c;
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        err_d        = err_q;

        if (pend_q) begin
            addr_d       = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            word_count_d = wc_inc;
            checksum_d   = checksum_q ^ wdata_q;
            pend_d       = 1'b0;
            pend_last_d  = 1'b0;
            if (pend_last_q) begin
                state_d = S_DONE;
            end else if (write_fills) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    addr_d       = '0;
                    word_count_d = '0;
                    checksum_d   = '0;
                    err_d        = 1'b0;
                    pend_d       = 1'b0;
                    pend_last_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (op_is_defined(op)) begin
                        pend_d      = 1'b1;
                        pend_last_d = in_last;
                        wdata_d     = encode(op, rs, rt, rd, func, imm, target);
                    end else begin
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            checksum_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign imem_we    = pend_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign busy       = (state_q == S_LOAD) || pend_q;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule
